cvp14_mem_arbiter: RTL

//  Shares the single CVP14 memory port (Addr/RD/WR/dataOut/DataIn) between two requesters:

---
 rtl/cvp14_mem_pkg.sv | 18 +
 rtl/cvp14_mem_arbiter_if.sv | 21 ++
 rtl/cvp14_mem_arbiter_rr_arbiter2.sv | 27 ++
 rtl/cvp14_mem_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cvp14_mem_pkg.sv
// Shared constants for the CVP14 memory-port arbiter.
// Requester IDs double as bit positions in the 2-bit req/gnt vectors.
package cvp14_mem_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int LANES  = 16;
   localparam int IDX_W  = $clog2(LANES);

   localparam logic FETCH = 1'b0;
   localparam logic VEC   = 1'b1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_F_RD   = 3'd1;
   localparam logic [2:0] S_F_RSP  = 3'd2;
   localparam logic [2:0] S_V_RD   = 3'd3;
   localparam logic [2:0] S_V_TAIL = 3'd4;
   localparam logic [2:0] S_V_WR   = 3'd5;
endpackage

// File: rtl/cvp14_mem_arbiter_if.sv
// External CVP14 memory port as seen by the arbiter (master)
// and by the memory (slave).
interface cvp14_mem_arbiter_if;
   import cvp14_mem_pkg::*;

   logic [ADDR_W-1:0] Addr;
   logic              RD;
   logic              WR;
   logic [DATA_W-1:0] dataOut;
   logic [DATA_W-1:0] DataIn;

   modport master (
      output Addr, RD, WR, dataOut,
      input  DataIn
   );

   modport slave (
      input  Addr, RD, WR, dataOut,
      output DataIn
   );
endinterface

// File: rtl/cvp14_mem_arbiter_rr_arbiter2.sv
// Two-way fetch/vector arbiter; CVP14_ARB_RR_EN selects round-robin,
// otherwise fixed priority with the vector unit winning ties.
module cvp14_mem_arbiter_rr_arbiter2
   import cvp14_mem_pkg::*;
(
   input  logic [1:0] req,
`ifdef CVP14_ARB_RR_EN
   input  logic       last_win,
`endif
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req[FETCH] && req[VEC]) begin
`ifdef CVP14_ARB_RR_EN
         if (last_win == VEC) gnt[FETCH] = 1'b1;
         else                 gnt[VEC]   = 1'b1;
`else
         gnt[VEC] = 1'b1;
`endif
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/cvp14_mem_arbiter.sv
// Shares the CVP14 memory port between instruction fetch and vector bursts.
// Optional round-robin tie-break: define CVP14_ARB_RR_EN.
module cvp14_mem_arbiter
   import cvp14_mem_pkg::*;
(
   input  logic              Clk1,
   input  logic              Reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              v_req,
   input  logic              v_we,
   input  logic [ADDR_W-1:0] v_base,
   input  logic [IDX_W-1:0]  v_cnt,
   output logic              v_gnt,
   output logic [IDX_W-1:0]  v_widx,
   input  logic [DATA_W-1:0] v_wdata,
   output logic              v_rvalid,
   output logic [IDX_W-1:0]  v_ridx,
   output logic [DATA_W-1:0] v_rdata,
   output logic              v_done,
   output logic              busy,
   cvp14_mem_arbiter_if.master mem
);

   logic [2:0]        state;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              idle;
   logic              lane_last;
   logic [ADDR_W-1:0] lane_addr;
`ifdef CVP14_ARB_RR_EN
   logic              last_win;
`endif

   assign idle      = (state == S_IDLE);
   assign lane_last = (idx == cnt_q);
   assign lane_addr = addr_q + ADDR_W'(idx);
   assign busy      = !idle;

   // Requests are only visible to the arbiter in IDLE.
   assign req[FETCH] = f_req & idle;
   assign req[VEC]   = v_req & idle;
   assign f_gnt      = gnt[FETCH];
   assign v_gnt      = gnt[VEC];

   cvp14_mem_arbiter_rr_arbiter2 u_rr_arbiter2 (
      .req      (req),
`ifdef CVP14_ARB_RR_EN
      .last_win (last_win),
`endif
      .gnt      (gnt)
   );

   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state  <= S_IDLE;
         idx    <= '0;
         cnt_q  <= '0;
         addr_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (gnt[FETCH]) begin
                  state  <= S_F_RD;
                  addr_q <= f_addr;
                  idx    <= '0;
               end else if (gnt[VEC]) begin
                  state  <= v_we ? S_V_WR : S_V_RD;
                  addr_q <= v_base;
                  cnt_q  <= v_cnt;
                  idx    <= '0;
               end
            end
            S_F_RD:   state <= S_F_RSP;
            S_F_RSP:  state <= S_IDLE;
            S_V_RD: begin
               idx <= idx + 1'b1;
               if (lane_last) state <= S_V_TAIL;
            end
            S_V_TAIL: state <= S_IDLE;
            S_V_WR: begin
               idx <= idx + 1'b1;
               if (lane_last) state <= S_IDLE;
            end
            default:  state <= S_IDLE;
         endcase
      end
   end

`ifdef CVP14_ARB_RR_EN
   always_ff @(posedge Clk1) begin
      if (Reset)           last_win <= VEC;
      else if (gnt[FETCH]) last_win <= FETCH;
      else if (gnt[VEC])   last_win <= VEC;
   end
`endif

   // Memory strobes and return data come from state flops only.
   always_comb begin
      mem.Addr    = '0;
      mem.RD      = 1'b0;
      mem.WR      = 1'b0;
      mem.dataOut = '0;
      f_rvalid    = 1'b0;
      f_rdata     = '0;
      v_widx      = '0;
      v_rvalid    = 1'b0;
      v_ridx      = '0;
      v_rdata     = '0;
      v_done      = 1'b0;
      unique case (1'b1)
         (state == S_F_RD): begin
            mem.RD   = 1'b1;
            mem.Addr = addr_q;
         end
         (state == S_F_RSP): begin
            f_rvalid = 1'b1;
            f_rdata  = mem.DataIn;
         end
         (state == S_V_RD): begin
            mem.RD   = 1'b1;
            mem.Addr = lane_addr;
            if (idx != '0) begin
               v_rvalid = 1'b1;
               v_ridx   = idx - 1'b1;
               v_rdata  = mem.DataIn;
            end
         end
         (state == S_V_TAIL): begin
            v_rvalid = 1'b1;
            v_ridx   = cnt_q;
            v_rdata  = mem.DataIn;
            v_done   = 1'b1;
         end
         (state == S_V_WR): begin
            mem.WR      = 1'b1;
            mem.Addr    = lane_addr;
            mem.dataOut = v_wdata;
            v_widx      = idx;
            v_done      = lane_last;
         end
         default: ;
      endcase
   end

endmodule
